// File: rtl/ma_dot_seq.sv
// Dot-product sequencer driving a shared multiply-add unit, one element per 3 cycles.
// Optional WAIT timeout with err pulse enabled by defining MA_SEQ_TIMEOUT_EN.
module ma_dot_seq #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [SIZE-1:0]   mem_a_data,
    input  logic [SIZE-1:0]   mem_b_data,
    output logic [SIZE-1:0]   ma_a,
    output logic [SIZE-1:0]   ma_b,
    output logic [SIZE-1:0]   ma_c,
    output logic              ma_valid,
    input  logic [SIZE-1:0]   ma_p,
    input  logic              ma_dvalid,
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   result,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [SIZE-1:0]   acc;
    logic              last;

    assign last     = ({1'b0, idx} == (len_q - 1'b1));
    assign mem_addr = idx;
    assign ma_c     = acc;
    assign busy     = (state != IDLE);

    // Memory data is only valid in the cycle after the fetch, so pass it straight through
    assign ma_a = (state == ISSUE) ? mem_a_data : '0;
    assign ma_b = (state == ISSUE) ? mem_b_data : '0;

`ifdef MA_SEQ_TIMEOUT_EN
    logic [3:0] tcnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            acc      <= '0;
            result   <= '0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            ma_valid <= 1'b0;
`ifdef MA_SEQ_TIMEOUT_EN
            tcnt     <= '0;
            err      <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            mem_en   <= 1'b0;
            ma_valid <= 1'b0;
`ifdef MA_SEQ_TIMEOUT_EN
            err      <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        idx   <= '0;
                        len_q <= len;
                        if (len == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state  <= FETCH;
                            mem_en <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state    <= ISSUE;
                    ma_valid <= 1'b1;
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MA_SEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (ma_dvalid) begin
                        acc <= ma_p;
                        if (last) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= ma_p;
                        end else begin
                            idx    <= idx + 1'b1;
                            state  <= FETCH;
                            mem_en <= 1'b1;
                        end
                    end
`ifdef MA_SEQ_TIMEOUT_EN
                    else if (tcnt == 4'd14) begin
                        tcnt  <= 4'd15;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 4'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ma_dot_seq.sv
// Scoreboard bench for ma_dot_seq with memory and multiply-add unit models.
// Expected issues and results come from a plain-arithmetic dot-product model.
module tb_ma_dot_seq;

    localparam int SIZE   = 8;
    localparam int ADDR_W = 4;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [SIZE-1:0]   mem_a_data = '0;
    logic [SIZE-1:0]   mem_b_data = '0;
    logic [SIZE-1:0]   ma_a, ma_b, ma_c;
    logic              ma_valid;
    logic [SIZE-1:0]   ma_p = '0;
    logic              ma_dvalid = 1'b0;
    logic              busy, done, err;
    logic [SIZE-1:0]   result;

    always #5 clk = ~clk;

    ma_dot_seq #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .ma_a(ma_a), .ma_b(ma_b), .ma_c(ma_c), .ma_valid(ma_valid),
        .ma_p(ma_p), .ma_dvalid(ma_dvalid),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    logic [SIZE-1:0] va [N];
    logic [SIZE-1:0] vb [N];
    bit              hold = 1'b0;
    int              cyc = 0;

    // Environment: synchronous-read operand memory and 1-cycle multiply-add unit
    always @(posedge clk) begin
        cyc++;
        if (mem_en) begin
            mem_a_data <= va[mem_addr];
            mem_b_data <= vb[mem_addr];
        end
        ma_dvalid <= ma_valid && !hold;
        ma_p      <= ma_a * ma_b + ma_c;
    end

    typedef struct {
        int a;
        int b;
        int c;
    } iss_t;
    typedef struct {
        int r;
        int c;
    } dn_t;

    iss_t iss_q[$];
    dn_t  dn_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en && iss_q.size() == 0)
                flag("spurious mem_en");
            if (ma_valid) begin
                if (iss_q.size() == 0) begin
                    flag("spurious ma_valid");
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("ma_a", int'(ma_a), e.a);
                    chk("ma_b", int'(ma_b), e.b);
                    chk("ma_c", int'(ma_c), e.c);
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    flag("spurious done");
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("result", int'(result), d.r);
                    chk("done cycle", cyc, d.c);
                    chk("busy at done", int'(busy), 1);
                end
            end
        end
    end

    // Reference: dot product mod 2^SIZE, done 3*len+1 cycles after the start cycle
    task automatic go(input int n);
        int acc;
        int s;
        s   = cyc;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            iss_q.push_back('{int'(va[i]), int'(vb[i]), acc});
            acc = (acc + int'(va[i]) * int'(vb[i])) % 256;
        end
        dn_q.push_back('{acc, s + 3 * n + 1});
        start = 1'b1;
        len   = (ADDR_W + 1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((iss_q.size() != 0 || dn_q.size() != 0) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (iss_q.size() != 0 || dn_q.size() != 0) begin
            flag("drain timeout");
            iss_q.delete();
            dn_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " err"}, int'(err), 0);
        chk({tag, " mem_en"}, int'(mem_en), 0);
        chk({tag, " ma_valid"}, int'(ma_valid), 0);
        chk({tag, " result"}, int'(result), 0);
        chk({tag, " ma_c"}, int'(ma_c), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < N; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3;
        vb[0] = 8'd4; vb[1] = 8'd5; vb[2] = 8'd6;
        go(3);
        drain();
        chk("basic result", int'(result), 32);

        va[0] = 8'd16; va[1] = 8'd16;
        vb[0] = 8'd16; vb[1] = 8'd1;
        go(2);
        drain();
        chk("wrap result", int'(result), 16);

        go(0);
        drain();
        chk("len0 result", int'(result), 0);

        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3;
        vb[0] = 8'd4; vb[1] = 8'd5; vb[2] = 8'd6;
        go(3);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        len   = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        go(3);
        drain();
        chk("restart result", int'(result), 32);

        for (int i = 0; i < N; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
        end
        go(3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrun reset");
        iss_q.delete();
        dn_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        va[0] = 8'd7;
        vb[0] = 8'd9;
        go(1);
        drain();
        chk("post-reset result", int'(result), 63);

        for (int r = 0; r < 24; r++) begin
            int n;
            for (int i = 0; i < N; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            n = (r == 0) ? N : int'($urandom_range(0, N));
            go(n);
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                len   = 5'($urandom_range(0, N));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            drain();
        end

`ifdef MA_SEQ_TIMEOUT_EN
        begin
            int s;
            int t;
            int rold;
            rold = int'(result);
            hold = 1'b1;
            s    = cyc;
            iss_q.push_back('{int'(va[0]), int'(vb[0]), 0});
            start = 1'b1;
            len   = 5'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
            t = 0;
            while (!err && t < 40) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("timeout err cycle", cyc, s + 18);
            chk("timeout err", int'(err), 1);
            chk("timeout busy", int'(busy), 0);
            chk("timeout result", int'(result), rold);
            @(posedge clk);
            #1;
            chk("err pulse width", int'(err), 0);
            hold = 1'b0;
            iss_q.delete();
        end
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
